// File: rtl/out_port_fifo.sv
// Output-port FIFO between the processor OUT strobe and an external consumer.
// The head word is kept in a register, so the consumer never sees a combinational path from out_data.
module out_port_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     out_strobe,
  input  logic [W-1:0]             out_data,
  output logic                     ext_valid,
  output logic [W-1:0]             ext_data,
  input  logic                     ext_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  always_comb begin
    full  = (count_q == CNT_MAX);
    empty = (count_q == '0);
    pop   = !empty && ext_ready;
    push  = out_strobe && (!full || pop);
    drop  = out_strobe && !push;

    wr_d = push ? wr_q + PTR_ONE : wr_q;
    rd_d = pop  ? rd_q + PTR_ONE : rd_q;

    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;

    // The next head is the incoming word when it lands on the new read slot,
    // otherwise whatever is already stored there; an empty FIFO keeps the old value.
    head_d = head_q;
    if (push && (wr_q == rd_d))
      head_d = out_data;
    else if (count_d != '0)
      head_d = mem_q[rd_d];

    ovf_d = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage has no reset; the gate keeps a push from landing during reset.
  always_ff @(posedge clk) begin
    if (push && rst)
      mem_q[wr_q] <= out_data;
  end

  assign ext_valid = !empty;
  assign ext_data  = head_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed and randomized bench for out_port_fifo against a queue-based reference model.
module tb_out_port_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          out_strobe;
  logic [W-1:0]  out_data;
  logic          ext_valid;
  logic [W-1:0]  ext_data;
  logic          ext_ready;
  logic          full;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          clr_ovf;

  out_port_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_strobe (out_strobe),
    .out_data   (out_data),
    .ext_valid  (ext_valid),
    .ext_data   (ext_data),
    .ext_ready  (ext_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq [$];
  bit           movf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},     32'(count),     32'(mq.size()));
    chk({tag, ".empty"},     32'(empty),     32'(mq.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    chk({tag, ".ext_valid"}, 32'(ext_valid), 32'(mq.size() != 0));
    chk({tag, ".overflow"},  32'(overflow),  32'(movf));
    if (mq.size() != 0)
      chk({tag, ".ext_data"}, 32'(ext_data), 32'(mq[0]));
    $display("step %s: s=%0b r=%0b c=%0b count=%0d head=%h ovf=%0b",
             tag, out_strobe, ext_ready, clr_ovf, count, ext_data, overflow);
  endtask

  // One clock: drive inputs, predict from the model, advance, then compare.
  task automatic step(input string tag, input bit s, input logic [W-1:0] d, input bit r, input bit c);
    bit mpop, mpush;
    out_strobe = s;
    out_data   = s ? d : 'x;
    ext_ready  = r;
    clr_ovf    = c;
    mpop  = (mq.size() > 0) && r;
    mpush = s && ((mq.size() < DEPTH) || mpop);
    @(posedge clk);
    if (mpop)  void'(mq.pop_front());
    if (mpush) mq.push_back(d);
    if (s && !mpush) movf = 1'b1;
    else if (c)      movf = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] sent [$];
    int pushed, recv, budget;
    bit s, r;
    logic [W-1:0] d;

    rst = 1'b0; out_strobe = 1'b0; out_data = '0; ext_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    check_all("reset");
    chk("reset.ext_data", 32'(ext_data), 32'h0);
    rst = 1'b1;

    // Single word
    step("single.idle", 0, '0, 0, 0);
    step("single.push", 1, 16'h1234, 0, 0);
    chk("single.data",  32'(ext_data), 32'h1234);
    chk("single.count", 32'(count),    32'd1);
    step("single.pop",  0, '0, 1, 0);
    chk("single.empty", 32'(empty),    32'd1);

    // Fill past full, then drain
    for (int i = 1; i <= 9; i++) step("fill9", 1, W'(i), 0, 0);
    chk("fill9.full",     32'(full),     32'd1);
    chk("fill9.count",    32'(count),    32'd8);
    chk("fill9.overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("drain.order", 32'(ext_data), 32'(i));
      step("drain", 0, '0, 1, 0);
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // Overflow clear
    step("clr", 0, '0, 0, 1);
    chk("clr.overflow", 32'(overflow), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) step("fill8", 1, W'(16'h0100 + i), 0, 0);
    step("fullpp", 1, 16'hAAAA, 1, 0);
    chk("fullpp.count",    32'(count),    32'd8);
    chk("fullpp.overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) step("fullpp.pop", 0, '0, 1, 0);
    chk("fullpp.head", 32'(ext_data), 32'hAAAA);
    step("fullpp.last", 0, '0, 1, 0);
    chk("fullpp.empty", 32'(empty), 32'd1);

    // Drop coincident with clear: set wins
    for (int i = 0; i < 8; i++) step("fill8b", 1, W'(16'h0200 + i), 0, 0);
    step("dropclr", 1, 16'hBEEF, 0, 1);
    chk("dropclr.overflow", 32'(overflow), 32'd1);
    step("clr2", 0, '0, 0, 1);
    for (int i = 0; i < 8; i++) step("drain2", 0, '0, 1, 0);

    // Random stream with backpressure across pointer wrap
    pushed = 0; recv = 0; budget = 0;
    while ((pushed < 20 || mq.size() != 0) && budget < 500) begin
      s = (pushed < 20) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      d = W'($urandom);
      r = ($urandom_range(0, 1) == 1);
      if (r && mq.size() != 0) begin
        chk("stream.order", 32'(ext_data), 32'(sent[recv]));
        recv++;
      end
      if (s) begin
        sent.push_back(d);
        pushed++;
      end
      step("stream", s, d, r, 0);
      chk("stream.bound", 32'(count <= 4'd8), 32'd1);
      budget++;
    end
    chk("stream.done", 32'(recv), 32'd20);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) step("pre_rst", 1, W'(16'h0300 + i), 0, 0);
    #2 rst = 1'b0;
    #1;
    mq.delete();
    movf = 1'b0;
    check_all("midrst");
    chk("midrst.ext_data", 32'(ext_data), 32'h0);
    out_strobe = 1'b1; out_data = 16'h5555; ext_ready = 1'b1;
    @(posedge clk);
    #1;
    check_all("inrst");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step("postrst", 0, '0, 1, 0);
    step("postrst.push", 1, 16'h7777, 0, 0);
    chk("postrst.data", 32'(ext_data), 32'h7777);

    out_strobe = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
